transfer_msr: RTL and testbench

TRANSFER_MSR -- requirements
Module: transfer_msr

---
 rtl/transfer_msr.sv | 165 ++++++++++++++++
 tb/tb_transfer_msr.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/transfer_msr.sv
// transfer_msr: periodic sample generator feeding a small FIFO, with a
// request/ready handshake that hands one sample word to an asynchronous host
// per rising edge of data_req.
module transfer_msr #(
    parameter int SAMPLE_PERIOD = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic        data_req,
    output logic        data_rdy,
    output logic [23:0] msr_data
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_READY     = 2'd2
    } state_t;

    // Request synchronizer and edge detector
    logic req_meta_r;
    logic req_sync_r;
    logic req_dly_r;
    logic req_edge_r;

    // Sample generator
    logic [CNT_W-1:0] tick_cnt_r;
    logic [23:0]      seq_r;
    logic             tick_s;

    // Sample FIFO
    logic [23:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   fifo_cnt_r;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;

    // Transfer FSM and registered outputs
    state_t      state_r;
    state_t      state_nx_s;
    logic        data_rdy_r;
    logic [23:0] msr_data_r;

    assign tick_s       = (tick_cnt_r == CNT_MAX);
    assign fifo_empty_s = (fifo_cnt_r == '0);
    assign fifo_full_s  = (fifo_cnt_r == FIFO_FULL);
    assign push_s       = tick_s && !fifo_full_s;

    assign data_rdy = data_rdy_r;
    assign msr_data = msr_data_r;

    // Two-flop synchronizer for data_req, then a registered one-cycle rising-edge pulse
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            req_meta_r <= 1'b0;
            req_sync_r <= 1'b0;
            req_dly_r  <= 1'b0;
            req_edge_r <= 1'b0;
        end else begin
            req_meta_r <= data_req;
            req_sync_r <= req_meta_r;
            req_dly_r  <= req_sync_r;
            req_edge_r <= req_sync_r & ~req_dly_r;
        end
    end

    // Tick counter and sequence number; the sequence advances on every tick, even when the sample is dropped
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r <= '0;
            seq_r      <= 24'h000000;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
            seq_r      <= seq_r + 24'h000001;
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

    // FIFO storage; only written when a slot is free, so a full FIFO keeps its contents
    always_ff @(posedge ref_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= seq_r;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W + 1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Transfer FSM next state; a pop is only issued from WAIT_DATA with data present
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_edge_r) begin
                    state_nx_s = ST_WAIT_DATA;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_READY;
                end else begin
                    state_nx_s = ST_WAIT_DATA;
                end
            end
            ST_READY: begin
                if (req_edge_r) begin
                    state_nx_s = ST_WAIT_DATA;
                end else begin
                    state_nx_s = ST_READY;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; msr_data only changes on a pop
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            data_rdy_r <= 1'b0;
            msr_data_r <= 24'h000000;
        end else begin
            state_r    <= state_nx_s;
            data_rdy_r <= (state_nx_s == ST_READY);
            if (pop_s) begin
                msr_data_r <= fifo_mem_r[rd_ptr_r];
            end
        end
    end

endmodule

// File: tb/tb_transfer_msr.sv
// Scoreboard bench for transfer_msr: requests push expected words, a monitor
// compares msr_data on every rising edge of data_rdy.
module tb_transfer_msr;

    logic        ref_clk;
    logic        rst;
    logic        data_req;
    logic        data_rdy;
    logic [23:0] msr_data;

    typedef struct packed {
        logic [23:0] val;
        bit          gt;   // 1: msr_data must be strictly greater than val
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   errors      = 0;
    bit   glitch_mode = 1'b0;
    int   glitch_rises = 0;
    logic prev_rdy    = 1'b0;

    transfer_msr #(.SAMPLE_PERIOD(4), .FIFO_DEPTH(8)) dut (
        .ref_clk  (ref_clk),
        .rst      (rst),
        .data_req (data_req),
        .data_rdy (data_rdy),
        .msr_data (msr_data)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Monitor: every new delivery is compared against the head of the scoreboard
    always @(negedge ref_clk) begin
        if (data_rdy === 1'b1 && prev_rdy !== 1'b1) begin
            checks++;
            if (glitch_mode) begin
                glitch_rises++;
                if (msr_data !== 24'h000000) begin
                    errors++;
                    $display("FAIL glitch_data: got %h expected 000000", msr_data);
                end
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: got %h with no request outstanding", msr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.gt ? !(msr_data > e.val) : (msr_data !== e.val)) begin
                    errors++;
                    $display("FAIL delivery: got %h expected %s%h", msr_data, e.gt ? ">" : "", e.val);
                end
            end
        end
        prev_rdy = data_rdy;
    end

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One 2-cycle-high request; waits (bounded) for the delivery, optionally checks latency
    task automatic do_req(input logic [23:0] val, input bit gt, input bit was_rdy, input int exp_lat);
        exp_t e;
        int   lat;
        bit   seen_low;
        @(negedge ref_clk);
        e.val = val;
        e.gt  = gt;
        sb.push_back(e);
        data_req = 1'b1;
        seen_low = !was_rdy;
        lat      = 0;
        @(posedge ref_clk);               // first edge sampling data_req high
        for (int k = 1; k <= 60; k++) begin
            @(posedge ref_clk);
            #1;
            if (k == 1) data_req = 1'b0;
            if (!seen_low && data_rdy === 1'b0) seen_low = 1'b1;
            if (seen_low && data_rdy === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: data_rdy never rose for expected %h", val);
        end else if (exp_lat != 0) begin
            check("latency", 24'(lat), 24'(exp_lat));
        end
    endtask

    task automatic reset_pulse(input int cycles);
        @(negedge ref_clk);
        rst = 1'b0;
        repeat (cycles) @(negedge ref_clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        data_req = 1'b0;

        // Reset held with data_req toggling: outputs stay cleared
        for (int i = 0; i < 5; i++) begin
            @(negedge ref_clk);
            data_req = ~data_req;
            #2;
            check("reset_rdy", 24'(data_rdy), 24'h0);
            check("reset_data", msr_data, 24'h000000);
        end
        @(negedge ref_clk);
        data_req = 1'b0;
        rst      = 1'b1;

        // Basic transfers with FIFO non-empty
        repeat (10) @(negedge ref_clk);
        do_req(24'h000000, 1'b0, 1'b0, 4);
        repeat (3) @(negedge ref_clk);
        check("hold_rdy", 24'(data_rdy), 24'h1);
        check("hold_data", msr_data, 24'h000000);
        do_req(24'h000001, 1'b0, 1'b1, 4);
        do_req(24'h000002, 1'b0, 1'b1, 4);
        repeat (3) @(negedge ref_clk);

        // Request right after reset release waits for the first sample
        reset_pulse(3);
        do_req(24'h000000, 1'b0, 1'b0, 0);
        repeat (2) @(negedge ref_clk);

        // Reset while data_rdy=1 clears outputs within the cycle
        check("pre_abort_rdy", 24'(data_rdy), 24'h1);
        @(negedge ref_clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_rdy", 24'(data_rdy), 24'h0);
        check("abort_data", msr_data, 24'h000000);
        repeat (3) @(negedge ref_clk);
        rst = 1'b1;
        repeat (10) @(negedge ref_clk);
        do_req(24'h000000, 1'b0, 1'b0, 4);

        // Overflow: idle 100 cycles, then 0..7 and a word past the dropped gap
        reset_pulse(3);
        repeat (100) @(negedge ref_clk);
        for (int i = 0; i < 8; i++) begin
            do_req(24'(i), 1'b0, (i != 0), 0);
        end
        do_req(24'h000018, 1'b1, 1'b1, 0);
        repeat (3) @(negedge ref_clk);

        // One-cycle glitch: never more than one transfer
        reset_pulse(3);
        repeat (20) @(negedge ref_clk);
        glitch_mode  = 1'b1;
        glitch_rises = 0;
        @(negedge ref_clk);
        data_req = 1'b1;
        @(negedge ref_clk);
        data_req = 1'b0;
        repeat (30) @(negedge ref_clk);
        glitch_mode = 1'b0;
        checks++;
        if (glitch_rises > 1) begin
            errors++;
            $display("FAIL glitch_count: got %0d transfers expected at most 1", glitch_rises);
        end

        check("sb_drained", 24'(sb.size()), 24'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
